bus_arbiter_lv1_lv2: RTL
========================

// Module: bus_arbiter_lv1_lv2
// PURPOSE
//  Arbitrates the shared L1<->L2 bus among all L1 caches (4 cores x {data, instr}).
//  Consumes bus_lv1_lv2_req_proc_* / bus_lv1_lv2_req_snoop from every L1 wrapper; returns the matching gnt.
//  Two independent channels:
//   - proc: one transaction owner at a time, round-robin.
//   - snoop: one snoop responder at a time, granted only while a proc owner is active.
// PARAMETERS
//  NUM_CORES    4   cores; snoop requester count
//  NUM_PROC_REQ 8   proc requesters; index 2c = core c data L1, 2c+1 = core c instr L1
//  TIMEOUT_CYC  256 max proc grant hold, in cycles (used only with BUS_ARB_TIMEOUT_EN)
// PORTS
//  clk                   in  1            single clock, posedge
//  rst_n                 in  1            asynchronous, active-low reset
//  bus_lv1_lv2_req_proc  in  NUM_PROC_REQ proc requests, level, held until done
//  bus_lv1_lv2_gnt_proc  out NUM_PROC_REQ proc grants, one-hot or zero
//  bus_lv1_lv2_req_snoop in  NUM_CORES    snoop requests, level
//  bus_lv1_lv2_gnt_snoop out NUM_CORES    snoop grants, one-hot or zero
//  proc_owner_id         out $clog2(NUM_PROC_REQ) index of current proc owner (valid when proc_busy)
//  proc_busy             out 1            proc grant active
//  arb_timeout           out 1            1-cycle pulse on forced release
// BEHAVIOUR
//  Reset: all outputs 0; both channels enter IDLE; rr pointers = 0 (index 0 highest priority); timeout counter = 0.
//  All outputs are registered. Reset assertion mid-transaction drops every grant immediately (asynchronous).
//  Proc FSM: IDLE -> GRANT -> RELEASE -> IDLE.
//   - IDLE: any req -> pick first set index scanning from rr_ptr upward with wrap.
//     Set gnt one-hot next edge (latency 1 cycle); proc_owner_id <= index; rr_ptr <= index+1 mod NUM_PROC_REQ.
//   - GRANT: gnt held while owner req=1. Owner req=0 sampled -> gnt drops next edge -> RELEASE.
//     Exception: snoop channel in GRANT at that edge -> stay in GRANT until snoop leaves GRANT.
//   - RELEASE: one dead cycle, all proc gnt=0; no arbitration. Next edge -> IDLE.
//   - Minimum req-to-req turnaround for a different requester: 3 cycles.
//  Snoop FSM: S_IDLE -> S_GRANT -> S_RELEASE -> S_IDLE.
//   - Arbitrates only while proc FSM is in GRANT.
//   - Eligible = req_snoop with bit (proc_owner_id>>1) masked: the owning core never snoops itself.
//   - Round-robin via its own snoop_rr_ptr, same wrap rule as proc.
//   - Grant held while req=1; drop on req=0 sampled; one dead cycle.
//   - Proc FSM leaving GRANT (timeout only) forces snoop gnt to 0 on the same edge -> S_RELEASE.
//  Simultaneous events:
//   - Req arriving during RELEASE waits; it is not lost (level request).
//   - Owner req drop and snoop req rise on the same edge: snoop is not granted (owner is leaving).
//   - Requests are held for the full transaction; a req withdrawn before gnt is simply not granted if sampled 0.
//  Invariants:
//   - $onehot0(gnt_proc), $onehot0(gnt_snoop).
//   - gnt_snoop != 0 implies gnt_proc != 0.
//   - gnt_snoop[proc_owner_id>>1] == 0.
// CONFIGURATION
//  BUS_ARB_TIMEOUT_EN defined:
//   - 16-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
//   - Reaching TIMEOUT_CYC-1 -> proc and snoop gnt forced 0 next edge, proc FSM -> RELEASE, arb_timeout=1 for that one cycle.
//   - rr_ptr keeps owner+1.
//  Not defined: no counter logic, arb_timeout tied 0, grants held indefinitely.
// TESTING
//  1 Reset: rst_n=0 mid-GRANT with req_proc=8'h01 -> all gnt 0 immediately; after release, gnt_proc=8'h01 one cycle after first sampled edge.
//  2 Round-robin: req_proc=8'h81 held, each owner drops after 4 cycles then re-asserts -> grant order 0,7,0,7; 3-cycle turnaround each.
//  3 Snoop: owner 2 (core1 dl) granted, req_snoop=4'b0011 -> gnt_snoop=4'b0001 only (core1 masked); drop -> 1 dead cycle, no regrant of core1.
//  4 Overlap: owner drops req while gnt_snoop=4'b0100 -> gnt_proc held until gnt_snoop=0, then RELEASE.
//  5 Wrap: rr_ptr=7, req_proc=8'h41 -> index 0 granted, rr_ptr=1; next grant index 6.
//  6 Timeout (BUS_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): req held 40 cycles -> gnt drops after 16 GRANT cycles, arb_timeout 1-cycle pulse, other pending req granted 2 cycles later.

Source files
------------

// File: rtl/bus_arbiter_lv1_lv2.sv
// bus_arbiter_lv1_lv2
// Shared L1<->L2 bus arbiter for 4 cores x {data, instr} L1 caches.
// Two channels:
//   proc  : one transaction owner at a time, round-robin over NUM_PROC_REQ
//           requesters (index 2c = core c data L1, 2c+1 = core c instr L1).
//   snoop : one snoop responder at a time, only while a proc owner holds the
//           bus; the owning core is never granted a snoop of itself.
// Optional feature macro: BUS_ARB_TIMEOUT_EN
//   When defined, a proc grant is forcibly released after TIMEOUT_CYC cycles
//   and arb_timeout pulses for one cycle. When undefined, grants are held for
//   as long as the owner keeps requesting and arb_timeout is tied low.
// All outputs are registered; rst_n is asynchronous and active-low.

module bus_arbiter_lv1_lv2 #(
  parameter int NUM_CORES    = 4,
  parameter int NUM_PROC_REQ = 8,
  parameter int TIMEOUT_CYC  = 256
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PROC_REQ-1:0]         bus_lv1_lv2_req_proc,
  output logic [NUM_PROC_REQ-1:0]         bus_lv1_lv2_gnt_proc,
  input  logic [NUM_CORES-1:0]            bus_lv1_lv2_req_snoop,
  output logic [NUM_CORES-1:0]            bus_lv1_lv2_gnt_snoop,
  output logic [$clog2(NUM_PROC_REQ)-1:0] proc_owner_id,
  output logic                            proc_busy,
  output logic                            arb_timeout
);

  localparam int PW = $clog2(NUM_PROC_REQ);
  localparam int SW = $clog2(NUM_CORES);

  localparam logic [NUM_PROC_REQ-1:0] PROC_ONE  = {{(NUM_PROC_REQ-1){1'b0}}, 1'b1};
  localparam logic [NUM_CORES-1:0]    SNOOP_ONE = {{(NUM_CORES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    P_IDLE    = 2'd0,
    P_GRANT   = 2'd1,
    P_RELEASE = 2'd2
  } proc_state_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } snoop_state_t;

  proc_state_t  proc_state;
  snoop_state_t snoop_state;

  logic [PW-1:0] rr_ptr;
  logic [SW-1:0] snoop_rr_ptr;
  logic [SW-1:0] snoop_owner_id;

  logic          proc_pick_valid;
  logic [PW-1:0] proc_pick_idx;
  logic          snoop_pick_valid;
  logic [SW-1:0] snoop_pick_idx;

  logic [NUM_CORES-1:0] snoop_eligible;
  logic [SW-1:0]        owner_core;
  logic                 owner_req;
  logic                 timeout_hit;

  // Index arithmetic modulo the proc requester count, used for rr scanning.
  function automatic logic [PW-1:0] wrap_add_p(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_PROC_REQ) sum = sum - NUM_PROC_REQ;
    return PW'(sum);
  endfunction

  // Index arithmetic modulo the core count, used for snoop rr scanning.
  function automatic logic [SW-1:0] wrap_add_s(input logic [SW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_CORES) sum = sum - NUM_CORES;
    return SW'(sum);
  endfunction

  assign owner_core = SW'(proc_owner_id >> 1);
  assign owner_req  = bus_lv1_lv2_req_proc[proc_owner_id];

  // Proc round-robin pick: first requester at or after rr_ptr, with wrap.
  // Scanning from the far end means the closest candidate is written last.
  always_comb begin
    proc_pick_valid = 1'b0;
    proc_pick_idx   = '0;
    for (int i = NUM_PROC_REQ - 1; i >= 0; i--) begin
      if (bus_lv1_lv2_req_proc[wrap_add_p(rr_ptr, i)]) begin
        proc_pick_valid = 1'b1;
        proc_pick_idx   = wrap_add_p(rr_ptr, i);
      end
    end
  end

  // Snoop candidates: the core that owns the proc channel never snoops itself.
  always_comb begin
    snoop_eligible             = bus_lv1_lv2_req_snoop;
    snoop_eligible[owner_core] = 1'b0;
  end

  // Snoop round-robin pick over the eligible set, same wrap rule as proc.
  always_comb begin
    snoop_pick_valid = 1'b0;
    snoop_pick_idx   = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (snoop_eligible[wrap_add_s(snoop_rr_ptr, i)]) begin
        snoop_pick_valid = 1'b1;
        snoop_pick_idx   = wrap_add_s(snoop_rr_ptr, i);
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [15:0] hold_cnt;

  assign timeout_hit = (proc_state == P_GRANT) && (hold_cnt == 16'(TIMEOUT_CYC - 1));

  // Hold counter: cleared when a grant is issued, counts every GRANT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (proc_state == P_IDLE && proc_pick_valid) begin
      hold_cnt <= '0;
    end else if (proc_state == P_GRANT) begin
      hold_cnt <= hold_cnt + 16'd1;
    end
  end

  // One-cycle pulse coinciding with the dead cycle after a forced release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_timeout <= 1'b0;
    end else begin
      arb_timeout <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign arb_timeout = 1'b0;
`endif

  // Proc channel FSM: IDLE -> GRANT -> RELEASE -> IDLE. The owner is held
  // in GRANT while a snoop responder is active so the snoop can complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proc_state           <= P_IDLE;
      bus_lv1_lv2_gnt_proc <= '0;
      proc_owner_id        <= '0;
      proc_busy            <= 1'b0;
      rr_ptr               <= '0;
    end else begin
      case (proc_state)
        P_IDLE: begin
          if (proc_pick_valid) begin
            bus_lv1_lv2_gnt_proc <= PROC_ONE << proc_pick_idx;
            proc_owner_id        <= proc_pick_idx;
            proc_busy            <= 1'b1;
            rr_ptr               <= wrap_add_p(proc_pick_idx, 1);
            proc_state           <= P_GRANT;
          end
        end
        P_GRANT: begin
          if (timeout_hit || (!owner_req && snoop_state != S_GRANT)) begin
            bus_lv1_lv2_gnt_proc <= '0;
            proc_busy            <= 1'b0;
            proc_state           <= P_RELEASE;
          end
        end
        P_RELEASE: begin
          proc_state <= P_IDLE;
        end
        default: begin
          bus_lv1_lv2_gnt_proc <= '0;
          proc_busy            <= 1'b0;
          proc_state           <= P_IDLE;
        end
      endcase
    end
  end

  // Snoop channel FSM: S_IDLE -> S_GRANT -> S_RELEASE -> S_IDLE. New snoop
  // grants only happen while the proc owner is staying; a forced proc
  // release pulls the snoop grant on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snoop_state           <= S_IDLE;
      bus_lv1_lv2_gnt_snoop <= '0;
      snoop_owner_id        <= '0;
      snoop_rr_ptr          <= '0;
    end else begin
      case (snoop_state)
        S_IDLE: begin
          if (proc_state == P_GRANT && owner_req && !timeout_hit && snoop_pick_valid) begin
            bus_lv1_lv2_gnt_snoop <= SNOOP_ONE << snoop_pick_idx;
            snoop_owner_id        <= snoop_pick_idx;
            snoop_rr_ptr          <= wrap_add_s(snoop_pick_idx, 1);
            snoop_state           <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (timeout_hit || !bus_lv1_lv2_req_snoop[snoop_owner_id]) begin
            bus_lv1_lv2_gnt_snoop <= '0;
            snoop_state           <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          snoop_state <= S_IDLE;
        end
        default: begin
          bus_lv1_lv2_gnt_snoop <= '0;
          snoop_state           <= S_IDLE;
        end
      endcase
    end
  end

endmodule
